// File: rtl/panel_scan.sv
// HUB75 1/8-scan panel driver: shifts 32 column pixel pairs per row and bit-plane
// from the framebuffer, then shows each plane for BASE<<plane cycles (BCM).
module panel_scan #(
  parameter int unsigned PLANES = 4,
  parameter int unsigned BASE   = 8
) (
  input  logic        pixclk,
  input  logic        reset,
  input  logic        display,
  input  logic [23:0] rd_data,
  output logic [8:0]  rd_addr,
  output logic        rd_bank,
  output logic        r0,
  output logic        g0,
  output logic        b0,
  output logic        r1,
  output logic        g1,
  output logic        b1,
  output logic [2:0]  a,
  output logic        sclk,
  output logic        lat,
  output logic        oe_n,
  output logic        frame_done
);

  localparam int unsigned PW = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int unsigned CW = $clog2(BASE << (PLANES - 1)) + 1;

  typedef enum logic [2:0] {
    RD_TOP, RD_BOT, DATA, CLK, LATCH, SHOW, BLANK
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      row_q, row_d;
  logic [4:0]      col_q, col_d;
  logic [PW-1:0]   plane_q, plane_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [23:0]     top_q, top_d;
  logic [8:0]      addr_q, addr_d;
  logic            bank_q, bank_d;
  logic [5:0]      rgb_q, rgb_d;
  logic [2:0]      a_q, a_d;
  logic            sclk_q, sclk_d;
  logic            lat_q, lat_d;
  logic            oe_n_q, oe_n_d;
  logic            fd_q, fd_d;

  logic [2:0]      bidx;
  logic [CW-1:0]   show_len;
  logic [7:0]      tr, tg, tb, br, bg, bb;

  assign bidx     = 3'(8 - PLANES) + 3'(plane_q);
  assign show_len = CW'(BASE) << plane_q;
  assign tr = top_q[23:16];
  assign tg = top_q[15:8];
  assign tb = top_q[7:0];
  assign br = rd_data[23:16];
  assign bg = rd_data[15:8];
  assign bb = rd_data[7:0];

  // Every output register takes the action of the current state, so pins lag the
  // state by one cycle; rd_data is therefore sampled one edge after its address.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    plane_d = plane_q;
    cnt_d   = cnt_q;
    top_d   = top_q;
    addr_d  = addr_q;
    bank_d  = bank_q;
    rgb_d   = rgb_q;
    a_d     = a_q;
    sclk_d  = 1'b0;
    lat_d   = 1'b0;
    oe_n_d  = 1'b1;
    fd_d    = 1'b0;
    case (state_q)
      RD_TOP: begin
        addr_d  = {1'b0, row_q, col_q};
        state_d = RD_BOT;
      end
      RD_BOT: begin
        addr_d  = {1'b1, row_q, col_q};
        top_d   = rd_data;
        state_d = DATA;
      end
      DATA: begin
        rgb_d   = {tr[bidx], tg[bidx], tb[bidx], br[bidx], bg[bidx], bb[bidx]};
        state_d = CLK;
      end
      CLK: begin
        sclk_d = 1'b1;
        if (col_q == 5'd31) begin
          col_d   = '0;
          state_d = LATCH;
        end else begin
          col_d   = col_q + 5'd1;
          state_d = RD_TOP;
        end
      end
      LATCH: begin
        lat_d   = 1'b1;
        a_d     = row_q;
        cnt_d   = '0;
        state_d = SHOW;
      end
      SHOW: begin
        oe_n_d = 1'b0;
        if (cnt_q == show_len - CW'(1)) state_d = BLANK;
        else                            cnt_d   = cnt_q + CW'(1);
      end
      BLANK: begin
        if (plane_q == PW'(PLANES - 1)) begin
          plane_d = '0;
          row_d   = row_q + 3'd1;
          if (row_q == 3'd7) begin
            fd_d   = 1'b1;
            bank_d = display;
          end
        end else begin
          plane_d = plane_q + PW'(1);
        end
        state_d = RD_TOP;
      end
      default: state_d = RD_TOP;
    endcase
  end

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      state_q <= RD_TOP;
      row_q   <= '0;
      col_q   <= '0;
      plane_q <= '0;
      cnt_q   <= '0;
      top_q   <= '0;
      addr_q  <= '0;
      bank_q  <= 1'b0;
      rgb_q   <= '0;
      a_q     <= '0;
      sclk_q  <= 1'b0;
      lat_q   <= 1'b0;
      oe_n_q  <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      plane_q <= plane_d;
      cnt_q   <= cnt_d;
      top_q   <= top_d;
      addr_q  <= addr_d;
      bank_q  <= bank_d;
      rgb_q   <= rgb_d;
      a_q     <= a_d;
      sclk_q  <= sclk_d;
      lat_q   <= lat_d;
      oe_n_q  <= oe_n_d;
      fd_q    <= fd_d;
    end
  end

  assign rd_addr    = addr_q;
  assign rd_bank    = bank_q;
  assign {r0, g0, b0, r1, g1, b1} = rgb_q;
  assign a          = a_q;
  assign sclk       = sclk_q;
  assign lat        = lat_q;
  assign oe_n       = oe_n_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_panel_scan.sv
// Scoreboard bench for panel_scan: expected column pixels are queued per plane
// from the bench's framebuffer model and popped on each sclk rise.
module tb_panel_scan;
  localparam int unsigned PLANES = 4;
  localparam int unsigned BASE   = 8;

  logic        pixclk = 1'b0;
  logic        reset  = 1'b1;
  logic        display = 1'b0;
  logic [23:0] rd_data;
  logic [8:0]  rd_addr;
  logic        rd_bank, r0, g0, b0, r1, g1, b1, sclk, lat, oe_n, frame_done;
  logic [2:0]  a;

  panel_scan #(.PLANES(PLANES), .BASE(BASE)) dut (
    .pixclk(pixclk), .reset(reset), .display(display), .rd_data(rd_data),
    .rd_addr(rd_addr), .rd_bank(rd_bank),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .a(a), .sclk(sclk), .lat(lat), .oe_n(oe_n), .frame_done(frame_done)
  );

  always #5 pixclk = ~pixclk;

  logic [23:0] mem [2][512];
  assign rd_data = mem[rd_bank][rd_addr];

  typedef struct {
    logic [5:0] rgb;
    logic [8:0] addr;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_plane(input int bank, input int row, input int plane);
    logic [23:0] t, b;
    exp_t x;
    int i;
    i = 8 - PLANES + plane;
    for (int c = 0; c < 32; c++) begin
      t = mem[bank][row*32 + c];
      b = mem[bank][256 + row*32 + c];
      x.rgb  = {t[16+i], t[8+i], t[i], b[16+i], b[8+i], b[i]};
      x.addr = 9'(256 + row*32 + c);
      sb.push_back(x);
    end
  endtask

  bit   mon_en = 1'b0;
  int   cyc = 0, sclk_cnt = 0, oe_run = 0;
  int   ex_plane = 0, ex_row = 0, ex_bank = 0;
  int   last_lat = -1, lat_plane = 0, last_fd = -1, fd_count = 0;
  logic prev_sclk = 1'b0, prev_oe = 1'b1;

  always @(negedge pixclk) begin
    if (mon_en) begin
      cyc++;
      if (sclk && !prev_sclk) begin
        if (sb.size() == 0) check("sb_empty", 1, 0);
        else begin
          e = sb.pop_front();
          check("rgb", {r0, g0, b0, r1, g1, b1}, e.rgb);
          check("addr", rd_addr, e.addr);
        end
        sclk_cnt++;
      end
      if (lat) begin
        check("nsclk", sclk_cnt, 32);
        check("a", a, ex_row);
        check("bank", rd_bank, ex_bank);
        if (last_lat >= 0) check("plane_len", cyc - last_lat, 130 + (BASE << lat_plane));
        last_lat  = cyc;
        lat_plane = ex_plane;
        sclk_cnt  = 0;
      end
      if (!oe_n) oe_run++;
      if (oe_n && !prev_oe) begin
        check("show_len", oe_run, BASE << ex_plane);
        oe_run = 0;
        if (ex_plane == PLANES - 1) begin
          ex_plane = 0;
          if (ex_row == 7) begin
            ex_row = 0;
            check("fd", frame_done, 1);
            ex_bank = display;
            check("bank_sw", rd_bank, display);
            if (last_fd >= 0) check("frame_len", cyc - last_fd, 5120);
            last_fd = cyc;
            fd_count++;
          end else begin
            ex_row++;
            check("fd", frame_done, 0);
          end
        end else begin
          ex_plane++;
          check("fd", frame_done, 0);
        end
        push_plane(ex_bank, ex_row, ex_plane);
      end else if (frame_done) begin
        check("fd_spurious", frame_done, 0);
      end
      prev_sclk = sclk;
      prev_oe   = oe_n;
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[0][i] = 24'hFF0000;
      mem[1][i] = (i < 256) ? {8'h50, 8'(i*7), 8'(i*13)} : {8'(i*5), 8'(i*3), 8'hA0};
    end
    push_plane(0, 0, 0);
    mon_en = 1'b1;
    repeat (3) @(negedge pixclk);
    check("rst_addr", rd_addr, 0);
    check("rst_bank", rd_bank, 0);
    check("rst_rgb", {r0, g0, b0, r1, g1, b1}, 0);
    check("rst_a", a, 0);
    check("rst_sclk", sclk, 0);
    check("rst_lat", lat, 0);
    check("rst_oe_n", oe_n, 1);
    check("rst_fd", frame_done, 0);
    reset = 1'b0;
    @(posedge pixclk); #1 check("addr_c1", rd_addr, 9'h000);
    @(posedge pixclk); #1 check("addr_c2", rd_addr, 9'h100);

    repeat (2000) @(negedge pixclk);
    display = 1'b1;
    @(posedge pixclk); #1 check("bank_hold0", rd_bank, 0);
    for (int k = 0; k < 10000 && fd_count < 1; k++) @(negedge pixclk);
    check("fd_wait1", fd_count >= 1, 1);
    repeat (2000) @(negedge pixclk);
    display = 1'b0;
    @(posedge pixclk); #1 check("bank_hold1", rd_bank, 1);
    for (int k = 0; k < 15000 && fd_count < 3; k++) @(negedge pixclk);
    check("fd_wait3", fd_count >= 3, 1);

    // asynchronous reset while the panel is lit
    mon_en = 1'b0;
    for (int k = 0; k < 1000 && oe_n !== 1'b0; k++) @(negedge pixclk);
    check("show_seen", oe_n, 0);
    #2 reset = 1'b1;
    #1 check("async_oe_n", oe_n, 1);
    check("async_lat", lat, 0);
    check("async_a", a, 0);
    @(negedge pixclk) reset = 1'b0;
    @(posedge pixclk); #1 check("re_addr_c1", rd_addr, 9'h000);
    @(posedge pixclk); #1 check("re_addr_c2", rd_addr, 9'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
